// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed writes at dispatch, retires the oldest
// completed entry, and on squash walks back youngest-first to undo register renaming.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned NUM_VREG  = 16,
    parameter int unsigned NUM_PREG  = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [$clog2(NUM_VREG)-1:0]   alloc_vreg,
    input  logic [$clog2(NUM_PREG)-1:0]   alloc_new_preg,
    input  logic [$clog2(NUM_PREG)-1:0]   alloc_old_preg,
    output logic [$clog2(ROB_DEPTH)-1:0]  alloc_tag,
    input  logic                          done_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]  done_tag,
    output logic                          reg_commit,
    output logic [$clog2(NUM_PREG)-1:0]   commit_addr,
    input  logic                          rollback_req,
    output logic                          rb_valid,
    output logic [$clog2(NUM_VREG)-1:0]   rb_vreg,
    output logic [$clog2(NUM_PREG)-1:0]   rb_old_preg,
    output logic [$clog2(NUM_PREG)-1:0]   rb_free_preg,
    output logic [$clog2(ROB_DEPTH):0]    count
);

    localparam int unsigned TW = $clog2(ROB_DEPTH);
    localparam int unsigned VW = $clog2(NUM_VREG);
    localparam int unsigned PW = $clog2(NUM_PREG);
    localparam int unsigned CW = TW + 1;

    typedef enum logic {
        NORMAL   = 1'b0,
        ROLLBACK = 1'b1
    } state_t;

    state_t                state;
    logic [TW-1:0]         head;
    logic [TW-1:0]         tail;
    logic [CW-1:0]         occupancy;
    logic [ROB_DEPTH-1:0]  valid;
    logic [ROB_DEPTH-1:0]  done;

    logic [VW-1:0]         vreg_mem     [ROB_DEPTH];
    logic [PW-1:0]         new_preg_mem [ROB_DEPTH];
    logic [PW-1:0]         old_preg_mem [ROB_DEPTH];

    logic [TW-1:0]         youngest;
    logic                  accept;

    assign youngest     = tail - TW'(1);
    assign accept       = alloc_valid && alloc_ready;
    assign alloc_tag    = tail;
    assign count        = occupancy;
    assign commit_addr  = old_preg_mem[head];
    assign rb_vreg      = vreg_mem[youngest];
    assign rb_old_preg  = old_preg_mem[youngest];
    assign rb_free_preg = new_preg_mem[youngest];

    // Handshake/status outputs decoded from registered state
    always_comb begin
        alloc_ready = 1'b0;
        reg_commit  = 1'b0;
        rb_valid    = 1'b0;
        case (state)
            NORMAL: begin
                alloc_ready = (occupancy < CW'(ROB_DEPTH)) && !rollback_req;
                reg_commit  = valid[head] && done[head] && !rollback_req;
            end
            ROLLBACK: begin
                rb_valid = (occupancy != '0);
            end
            default: ;
        endcase
    end

    // Payload storage; only written on an accepted dispatch
    always_ff @(posedge clk) begin
        if (accept) begin
            vreg_mem[tail]     <= alloc_vreg;
            new_preg_mem[tail] <= alloc_new_preg;
            old_preg_mem[tail] <= alloc_old_preg;
        end
    end

    // Control state: pointers, occupancy, per-slot valid/done and mode
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= NORMAL;
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            valid     <= '0;
            done      <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    // Completion of an unoccupied slot is a stale report and is dropped
                    if (done_valid && valid[done_tag]) begin
                        done[done_tag] <= 1'b1;
                    end
                    if (accept) begin
                        valid[tail] <= 1'b1;
                        done[tail]  <= 1'b0;
                        tail        <= tail + TW'(1);
                    end
                    if (reg_commit) begin
                        valid[head] <= 1'b0;
                        done[head]  <= 1'b0;
                        head        <= head + TW'(1);
                    end
                    occupancy <= occupancy + CW'(accept) - CW'(reg_commit);
                    if (rollback_req && (occupancy != '0)) begin
                        state <= ROLLBACK;
                    end
                end
                ROLLBACK: begin
                    if (rb_valid) begin
                        valid[youngest] <= 1'b0;
                        done[youngest]  <= 1'b0;
                        tail            <= youngest;
                        occupancy       <= occupancy - CW'(1);
                        if (occupancy == CW'(1)) begin
                            state <= NORMAL;
                        end
                    end else begin
                        state <= NORMAL;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule
